// File: rtl/zone_sequencer_if.sv
// Control/status bundle between the irrigation controller and the zone sequencer.
// The bench drives the master side; the sequencer sits on the slave side.
interface zone_sequencer_if #(
  parameter int DUR_WIDTH = 6
);
  logic                 tick_1hz;
  logic                 start;
  logic                 abort;
  logic                 rain;
  logic [3:0]           quota_exceeded;
  logic                 dur_wr;
  logic [1:0]           dur_zone;
  logic [DUR_WIDTH-1:0] dur_set;
  logic [1:0]           zone_sel;
  logic                 zone_valve_req;
  logic                 seq_active;
  logic                 cycle_done;
  logic [DUR_WIDTH-1:0] secs_left;
  logic [3:0]           skipped;
  logic [2:0]           state_dbg;

  modport master (
    output tick_1hz, start, abort, rain, quota_exceeded, dur_wr, dur_zone, dur_set,
    input  zone_sel, zone_valve_req, seq_active, cycle_done, secs_left, skipped, state_dbg
  );

  modport slave (
    input  tick_1hz, start, abort, rain, quota_exceeded, dur_wr, dur_zone, dur_set,
    output zone_sel, zone_valve_req, seq_active, cycle_done, secs_left, skipped, state_dbg
  );
endinterface

// File: rtl/zone_sequencer.sv
// Automatic watering sequencer: steps zones 0..3 once per start, with per-zone
// durations, a valve-off settle gap between zones, and rain/quota/abort handling.
module zone_sequencer #(
  parameter int DUR_WIDTH   = 6,
  parameter int SETTLE_SECS = 2,
  parameter int DUR_RESET   = 5
) (
  input logic clk,
  input logic rst_n,
  zone_sequencer_if.slave bus
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SELECT = 3'd1;
  localparam logic [2:0] S_WATER  = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [5:0]           SETTLE_LAST = 6'(SETTLE_SECS - 1);
  localparam logic [DUR_WIDTH-1:0] DUR_INIT    = DUR_WIDTH'(DUR_RESET);
  localparam logic [DUR_WIDTH-1:0] ONE         = DUR_WIDTH'(1);

  logic [2:0]           state, state_n;
  logic [1:0]           zone_q, zone_n;
  logic [DUR_WIDTH-1:0] left_q, left_n;
  logic [3:0]           skip_q, skip_n;
  logic [5:0]           settle_q, settle_n;
  logic                 valve_q;
  logic                 adv;
  logic [DUR_WIDTH-1:0] dur [4];

  always_comb begin
    state_n  = state;
    zone_n   = zone_q;
    left_n   = left_q;
    skip_n   = skip_q;
    settle_n = settle_q;
    adv      = 1'b0;
    if (state != S_IDLE && bus.abort) begin
      state_n  = S_IDLE;
      zone_n   = 2'd0;
      left_n   = '0;
      settle_n = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start && !bus.rain) begin
            skip_n  = 4'b0000;
            zone_n  = 2'd0;
            state_n = S_SELECT;
          end
        end
        S_SELECT: begin
          if (bus.quota_exceeded[zone_q] || dur[zone_q] == '0) begin
            skip_n[zone_q] = 1'b1;
            adv            = 1'b1;
          end else begin
            left_n  = dur[zone_q];
            state_n = S_WATER;
          end
        end
        S_WATER: begin
          // Rain or quota cut watering short; the zone still counts as watered.
          if (bus.rain || bus.quota_exceeded[zone_q]) begin
            left_n   = '0;
            settle_n = '0;
            state_n  = S_SETTLE;
          end else if (bus.tick_1hz) begin
            left_n = left_q - ONE;
            if (left_q == ONE) begin
              settle_n = '0;
              state_n  = S_SETTLE;
            end
          end
        end
        S_SETTLE: begin
          if (bus.tick_1hz) begin
            if (settle_q == SETTLE_LAST) adv = 1'b1;
            else                         settle_n = settle_q + 6'd1;
          end
        end
        S_DONE: begin
          state_n = S_IDLE;
          zone_n  = 2'd0;
          left_n  = '0;
        end
        default: state_n = S_IDLE;
      endcase
      // Zone index saturates at 3 within one cycle; DONE follows the last zone.
      if (adv) begin
        settle_n = '0;
        if (zone_q == 2'd3) state_n = S_DONE;
        else begin
          zone_n  = zone_q + 2'd1;
          state_n = S_SELECT;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      zone_q   <= 2'd0;
      left_q   <= '0;
      skip_q   <= 4'b0000;
      settle_q <= '0;
      valve_q  <= 1'b0;
    end else begin
      state    <= state_n;
      zone_q   <= zone_n;
      left_q   <= left_n;
      skip_q   <= skip_n;
      settle_q <= settle_n;
      valve_q  <= (state_n == S_WATER);
    end
  end

  // Durations are sampled only in SELECT, so a write mid-zone applies next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) dur[i] <= DUR_INIT;
    end else if (bus.dur_wr) begin
      dur[bus.dur_zone] <= bus.dur_set;
    end
  end

  assign bus.zone_sel       = zone_q;
  assign bus.zone_valve_req = valve_q;
  assign bus.seq_active     = (state != S_IDLE);
  assign bus.cycle_done     = (state == S_DONE);
  assign bus.secs_left      = left_q;
  assign bus.skipped        = skip_q;
  assign bus.state_dbg      = state;
endmodule

// File: tb/tb_zone_sequencer.sv
// Bench for zone_sequencer: directed scenarios plus randomized traffic, all
// outputs compared every cycle against a behavioural model of the sequence.
module tb_zone_sequencer;
  localparam int DW = 6;
  localparam int SETTLE = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  zone_sequencer_if #(.DUR_WIDTH(DW)) bus ();

  zone_sequencer #(.DUR_WIDTH(DW), .SETTLE_SECS(SETTLE), .DUR_RESET(5)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: where the sequence is, which zone, how long is left.
  localparam int P_IDLE = 0, P_SELECT = 1, P_WATER = 2, P_SETTLE = 3, P_DONE = 4;
  int         m_phase, m_zone, m_left, m_settle_rem;
  logic [3:0] m_skip;
  int         m_dur [4];

  function automatic void model_reset();
    m_phase = P_IDLE; m_zone = 0; m_left = 0; m_settle_rem = 0; m_skip = 4'b0;
    for (int i = 0; i < 4; i++) m_dur[i] = 5;
  endfunction

  function automatic void model_next_zone();
    if (m_zone == 3) m_phase = P_DONE;
    else begin m_zone++; m_phase = P_SELECT; end
  endfunction

  function automatic void model_edge(input logic t, s, a, r, input logic [3:0] q,
                                     input logic dw, input int dz, input int ds);
    if (m_phase != P_IDLE && a) begin
      m_phase = P_IDLE; m_zone = 0; m_left = 0;
    end else if (m_phase == P_IDLE) begin
      if (s && !r) begin m_skip = 4'b0; m_zone = 0; m_phase = P_SELECT; end
    end else if (m_phase == P_SELECT) begin
      if (q[m_zone] || m_dur[m_zone] == 0) begin m_skip[m_zone] = 1'b1; model_next_zone(); end
      else begin m_left = m_dur[m_zone]; m_phase = P_WATER; end
    end else if (m_phase == P_WATER) begin
      if (r || q[m_zone]) begin m_left = 0; m_phase = P_SETTLE; m_settle_rem = SETTLE; end
      else if (t) begin
        m_left--;
        if (m_left == 0) begin m_phase = P_SETTLE; m_settle_rem = SETTLE; end
      end
    end else if (m_phase == P_SETTLE) begin
      if (t) begin
        m_settle_rem--;
        if (m_settle_rem == 0) model_next_zone();
      end
    end else begin
      m_phase = P_IDLE; m_zone = 0; m_left = 0;
    end
    if (dw) m_dur[dz] = ds;
  endfunction

  function automatic logic [31:0] pack_dut();
    return {17'b0, bus.zone_sel, bus.zone_valve_req, bus.seq_active, bus.cycle_done,
            bus.secs_left, bus.skipped};
  endfunction

  function automatic logic [31:0] pack_model();
    return {17'b0, 2'(m_zone), m_phase == P_WATER, m_phase != P_IDLE, m_phase == P_DONE,
            6'(m_left), m_skip};
  endfunction

  int valve_ticks [4];
  int done_cnt, hi23_cnt, cyc;

  function automatic void clear_stats();
    for (int i = 0; i < 4; i++) valve_ticks[i] = 0;
    done_cnt = 0; hi23_cnt = 0;
  endfunction

  // One clock: inputs are held across the edge, pulse inputs drop afterwards.
  task automatic step(input logic t);
    logic v_pre;
    int   z_pre;
    bus.tick_1hz = t;
    v_pre = bus.zone_valve_req;
    z_pre = bus.zone_sel;
    @(posedge clk);
    model_edge(t, bus.start, bus.abort, bus.rain, bus.quota_exceeded,
               bus.dur_wr, int'(bus.dur_zone), int'(bus.dur_set));
    #1;
    check("outputs", pack_dut(), pack_model());
    if (v_pre && t) valve_ticks[z_pre]++;
    if (bus.cycle_done) done_cnt++;
    if (bus.zone_valve_req && bus.zone_sel >= 2'd2) hi23_cnt++;
    bus.tick_1hz = 1'b0; bus.start = 1'b0; bus.abort = 1'b0; bus.dur_wr = 1'b0;
    cyc++;
  endtask

  task automatic tstep();
    step(cyc % 3 == 0);
  endtask

  task automatic run_to_idle();
    int i;
    for (i = 0; i < 600; i++) begin
      tstep();
      if (!bus.seq_active) break;
    end
    check("idle_reached", 32'(i < 600), 32'd1);
  endtask

  // Wait for watering of zone z; l >= 0 also requires that many seconds left.
  task automatic wait_water(input int z, input int l);
    int i;
    for (i = 0; i < 600; i++) begin
      if (bus.zone_valve_req && bus.zone_sel == 2'(z) && (l < 0 || bus.secs_left == 6'(l))) break;
      tstep();
    end
    check("water_reached", 32'(i < 600), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("reset_outputs", pack_dut(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic write_dur(input int z, input int v);
    bus.dur_wr = 1'b1; bus.dur_zone = 2'(z); bus.dur_set = 6'(v);
    tstep();
  endtask

  task automatic check_five_each();
    for (int z = 0; z < 4; z++) check($sformatf("ticks_zone%0d", z), 32'(valve_ticks[z]), 32'd5);
  endtask

  initial begin
    int ticks;
    bus.tick_1hz = 0; bus.start = 0; bus.abort = 0; bus.rain = 0;
    bus.quota_exceeded = 4'b0; bus.dur_wr = 0; bus.dur_zone = 0; bus.dur_set = 0;
    cyc = 0;
    #12;
    do_reset();

    // Plain full cycle with reset durations.
    clear_stats();
    bus.start = 1'b1; tstep();
    check("active_after_start", 32'(bus.seq_active), 32'd1);
    run_to_idle();
    check_five_each();
    check("done_pulses", 32'(done_cnt), 32'd1);
    check("skipped_none", 32'(bus.skipped), 32'd0);

    // Quota on zone 2 and zero duration on zone 3.
    write_dur(3, 0);
    bus.quota_exceeded = 4'b0100;
    clear_stats();
    bus.start = 1'b1; tstep();
    run_to_idle();
    check("skipped_2_3", 32'(bus.skipped), 32'b1100);
    check("valve_zone_2_3", 32'(hi23_cnt), 32'd0);
    bus.quota_exceeded = 4'b0;
    write_dur(3, 5);

    // Rain part-way through zone 1.
    clear_stats();
    bus.start = 1'b1; tstep();
    wait_water(1, 3);
    bus.rain = 1'b1; step(1'b0);
    bus.rain = 1'b0;
    check("rain_valve_off", 32'(bus.zone_valve_req), 32'd0);
    check("rain_secs_zero", 32'(bus.secs_left), 32'd0);
    ticks = 0;
    for (int i = 0; i < 100 && bus.zone_sel != 2'd2; i++) begin
      ticks += (cyc % 3 == 0) ? 1 : 0;
      tstep();
    end
    check("rain_settle_ticks", 32'(ticks), SETTLE);
    check("rain_zone1_not_skipped", 32'(bus.skipped[1]), 32'd0);
    run_to_idle();

    // Abort coinciding with a tick in zone 2.
    clear_stats();
    bus.start = 1'b1; tstep();
    wait_water(2, -1);
    bus.abort = 1'b1; step(1'b1);
    check("abort_inactive", 32'(bus.seq_active), 32'd0);
    check("abort_valve", 32'(bus.zone_valve_req), 32'd0);
    check("abort_zone", 32'(bus.zone_sel), 32'd0);
    check("abort_no_done", 32'(done_cnt), 32'd0);

    // Start ignored under rain, and ignored mid-cycle.
    bus.rain = 1'b1; bus.start = 1'b1; tstep();
    bus.rain = 1'b0;
    check("start_in_rain", 32'(bus.seq_active), 32'd0);
    clear_stats();
    bus.start = 1'b1; tstep();
    wait_water(0, -1);
    bus.start = 1'b1; tstep();
    check("restart_zone", 32'(bus.zone_sel), 32'd0);
    run_to_idle();
    check_five_each();
    check("restart_done", 32'(done_cnt), 32'd1);

    // Asynchronous reset during zone 1 restores durations too.
    write_dur(0, 9);
    bus.start = 1'b1; tstep();
    wait_water(1, -1);
    #2;
    do_reset();
    clear_stats();
    bus.start = 1'b1; tstep();
    run_to_idle();
    check_five_each();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(19, 0) == 0) bus.start = 1'b1;
      if ($urandom_range(149, 0) == 0) bus.abort = 1'b1;
      if ($urandom_range(59, 0) == 0) bus.rain = ~bus.rain;
      if ($urandom_range(79, 0) == 0)
        bus.quota_exceeded = ($urandom_range(2, 0) == 0) ? 4'($urandom_range(15, 0)) : 4'b0;
      if ($urandom_range(29, 0) == 0) begin
        bus.dur_wr = 1'b1; bus.dur_zone = 2'($urandom_range(3, 0));
        bus.dur_set = 6'($urandom_range(9, 0));
      end
      step($urandom_range(2, 0) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
